// File: rtl/counter_arbiter.sv
// Round-robin arbiter that serialises per-requester increment/decrement requests
// into single-cycle up/down pulses for a shared saturating up/down counter.
module counter_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 4,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_up,
   input  logic [NREQ-1:0]  req_down,
   input  logic [WIDTH-1:0] value,
   output logic             up,
   output logic             down,
   output logic [NREQ-1:0]  gnt,
   output logic [NREQ-1:0]  rej,
   output logic             busy
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          state;
   logic [PW-1:0]   ptr;

   logic            found;
   logic [PW-1:0]   sel;
   int              sidx;
   logic [NREQ-1:0] sel_oh;
   logic [PW-1:0]   nxt_ptr;
   logic            conflict;
   logic            blocked;

   // True when stepping in the requested direction would leave [MIN_VAL, MAX_VAL].
   function automatic logic limit_hit(input logic is_up, input logic [WIDTH-1:0] v);
      if (is_up) return (v >= WIDTH'(MAX_VAL));
      else       return (v <= WIDTH'(MIN_VAL));
   endfunction

   // Selection: first active requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      sidx  = 0;
      for (int off = 0; off < NREQ; off++) begin
         sidx = (int'(ptr) + off) % NREQ;
         if (!found && (req_up[sidx] || req_down[sidx])) begin
            found = 1'b1;
            sel   = PW'(sidx);
         end
      end
   end

   assign sel_oh   = {{(NREQ-1){1'b0}}, 1'b1} << sel;
   assign nxt_ptr  = (sel == PW'(NREQ-1)) ? '0 : sel + 1'b1;
   assign conflict = req_up[sel] & req_down[sel];
   assign blocked  = conflict | limit_hit(req_up[sel], value);

   // Registered outputs: every pulse lasts exactly one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         up    <= 1'b0;
         down  <= 1'b0;
         gnt   <= '0;
         rej   <= '0;
         busy  <= 1'b0;
      end else begin
         up   <= 1'b0;
         down <= 1'b0;
         gnt  <= '0;
         rej  <= '0;
         busy <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  ptr <= nxt_ptr;
                  if (blocked) begin
                     rej <= sel_oh;
                  end else begin
                     gnt   <= sel_oh;
                     up    <= req_up[sel];
                     down  <= req_down[sel];
                     busy  <= 1'b1;
                     state <= ISSUE;
                  end
               end
            end
            // Counter steps on the edge ending this cycle; next IDLE sees the new value.
            ISSUE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
